// File: rtl/dds_pkg.sv
// Shared encodings and default widths for the DDS sweep generator.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_TONE = 2'd0,
    MODE_SAW  = 2'd1,
    MODE_TRI  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_UP   = 2'd1,
    ST_RUN_DOWN = 2'd2
  } state_e;

  localparam int DEF_PHASE_W = 32;
  localparam int DEF_OUT_W   = 16;
  localparam int DEF_LUT_AW  = 10;
  localparam int DEF_DWELL_W = 16;

endpackage

// File: rtl/dds_sine_rom.sv
// Dual-read quarter-wave sine magnitude ROM, one registered cycle per read, no stall.
// Entries sample the midpoint of each bin so the four quadrant mirrors meet without repeats.
module dds_sine_rom
  import dds_pkg::*;
#(
  parameter int LUT_AW = DEF_LUT_AW,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic              GCLK,
  input  logic              reset,
  input  logic [LUT_AW-1:0] i_addr_a,
  input  logic [LUT_AW-1:0] i_addr_b,
  output logic [OUT_W-2:0]  o_dat_a,
  output logic [OUT_W-2:0]  o_dat_b
);

  localparam int DEPTH = 2 ** LUT_AW;

  // Taylor series keeps the table a pure elaboration-time constant.
  function automatic logic [OUT_W-2:0] rom_val(input int idx);
    real x;
    real term;
    real sum;
    real amp;
    x    = 3.14159265358979323846 * real'(2 * idx + 1) / real'(2 ** (LUT_AW + 2));
    term = x;
    sum  = x;
    for (int k = 1; k < 14; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    amp = real'((2 ** (OUT_W - 1)) - 1);
    return (OUT_W - 1)'($rtoi(amp * sum + 0.5));
  endfunction

  logic [OUT_W-2:0] w_rom [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam logic [OUT_W-2:0] VAL = rom_val(gi);
    assign w_rom[gi] = VAL;
  end

  always_ff @(posedge GCLK or negedge reset) begin
    if (!reset) begin
      o_dat_a <= '0;
      o_dat_b <= '0;
    end else begin
      o_dat_a <= w_rom[i_addr_a];
      o_dat_b <= w_rom[i_addr_b];
    end
  end

endmodule

// File: rtl/dds_sweep_gen.sv
// Phase-accumulator DDS with tone/saw/triangle frequency sweep; {sin,cos} 3 cycles after phase.
// Free-running output with no backpressure; config accepted only while idle (cfg_ready).
module dds_sweep_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int LUT_AW  = DEF_LUT_AW,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               GCLK,
  input  logic               reset,
  input  logic               MODULE_ENA,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_mode,
  input  logic [PHASE_W-1:0] cfg_fstart,
  input  logic [PHASE_W-1:0] cfg_fstop,
  input  logic [PHASE_W-1:0] cfg_fstep,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic               DDS_DATA_VALID,
  output logic [2*OUT_W-1:0] DDS_DATA,
  output logic [PHASE_W-1:0] CUR_FREQ,
  output logic               sweep_done,
  output logic               busy
);

  logic [1:0]         r_mode;
  logic [PHASE_W-1:0] r_fstart;
  logic [PHASE_W-1:0] r_fstop;
  logic [PHASE_W-1:0] r_fstep;
  logic [DWELL_W-1:0] r_dwell;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_freq;
  logic [PHASE_W-1:0] w_freq_nxt;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic               r_done;
  logic               w_done_nxt;

  logic               r_v1;
  logic               r_v2;
  logic [LUT_AW-1:0]  r_addr_s;
  logic [LUT_AW-1:0]  r_addr_c;
  logic               r_neg_s1;
  logic               r_neg_c1;
  logic               r_neg_s2;
  logic               r_neg_c2;
  logic [2*OUT_W-1:0] r_data;
  logic               r_data_vld;

  logic               w_cfg_hs;
  logic [PHASE_W-1:0] w_span;
  logic               w_sweep_ok;
  logic               w_is_saw;
  logic               w_is_tri;
  logic               w_tick;
  logic [PHASE_W:0]   w_up;
  logic [PHASE_W:0]   w_dn;
  logic               w_up_ok;
  logic               w_dn_ok;
  logic [1:0]         w_q;
  logic [1:0]         w_qc;
  logic [LUT_AW-1:0]  w_a;
  logic [OUT_W-2:0]   w_mag_s;
  logic [OUT_W-2:0]   w_mag_c;
  logic [OUT_W-1:0]   w_sin;
  logic [OUT_W-1:0]   w_cos;

  assign w_cfg_hs   = cfg_valid && (r_state == ST_IDLE);
  assign w_span     = r_fstop - r_fstart;
  assign w_sweep_ok = (r_fstop > r_fstart) && (r_fstep != '0) && (r_fstep <= w_span);
  assign w_is_saw   = w_sweep_ok && (r_mode == MODE_SAW);
  assign w_is_tri   = w_sweep_ok && (r_mode == MODE_TRI);
  assign w_tick     = (r_dwell_cnt == r_dwell);

  // Extra top bit carries the overflow/borrow of the step.
  assign w_up    = {1'b0, r_freq} + {1'b0, r_fstep};
  assign w_dn    = {1'b0, r_freq} - {1'b0, r_fstep};
  assign w_up_ok = !w_up[PHASE_W] && (w_up[PHASE_W-1:0] <= r_fstop);
  assign w_dn_ok = !w_dn[PHASE_W] && (w_dn[PHASE_W-1:0] >= r_fstart);

  always_ff @(posedge GCLK or negedge reset) begin
    if (!reset) begin
      r_mode   <= '0;
      r_fstart <= '0;
      r_fstop  <= '0;
      r_fstep  <= '0;
      r_dwell  <= '0;
    end else if (w_cfg_hs) begin
      r_mode   <= cfg_mode;
      r_fstart <= cfg_fstart;
      r_fstop  <= cfg_fstop;
      r_fstep  <= cfg_fstep;
      r_dwell  <= cfg_dwell;
    end
  end

  always_ff @(posedge GCLK or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_freq_nxt  = r_freq;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_freq_nxt = w_cfg_hs ? cfg_fstart : r_fstart;
        if (MODULE_ENA) w_state_nxt = ST_RUN_UP;
      end
      ST_RUN_UP: begin
        if (w_tick && (w_is_saw || w_is_tri)) begin
          if (w_up_ok) begin
            w_freq_nxt = w_up[PHASE_W-1:0];
          end else if (w_is_tri) begin
            w_state_nxt = ST_RUN_DOWN;
            w_freq_nxt  = w_dn[PHASE_W-1:0];
          end else begin
            w_freq_nxt = r_fstart;
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_RUN_DOWN: begin
        if (w_tick && w_is_tri) begin
          if (w_dn_ok) begin
            w_freq_nxt = w_dn[PHASE_W-1:0];
            w_done_nxt = (w_dn[PHASE_W-1:0] == r_fstart);
          end else begin
            w_state_nxt = ST_RUN_UP;
            w_freq_nxt  = w_up[PHASE_W-1:0];
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!MODULE_ENA) begin
      w_state_nxt = ST_IDLE;
      w_freq_nxt  = w_cfg_hs ? cfg_fstart : r_fstart;
      w_done_nxt  = 1'b0;
    end
  end

  // Quadrant folding: odd quadrants read the mirrored address, upper half negates.
  assign w_q  = r_phase[PHASE_W-1 -: 2];
  assign w_qc = w_q + 2'd1;
  assign w_a  = r_phase[PHASE_W-3 -: LUT_AW];

  dds_sine_rom #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_rom (
    .GCLK     (GCLK),
    .reset    (reset),
    .i_addr_a (r_addr_s),
    .i_addr_b (r_addr_c),
    .o_dat_a  (w_mag_s),
    .o_dat_b  (w_mag_c)
  );

  assign w_sin = r_neg_s2 ? -{1'b0, w_mag_s} : {1'b0, w_mag_s};
  assign w_cos = r_neg_c2 ? -{1'b0, w_mag_c} : {1'b0, w_mag_c};

  always_ff @(posedge GCLK or negedge reset) begin
    if (!reset) begin
      r_phase     <= '0;
      r_freq      <= '0;
      r_dwell_cnt <= '0;
      r_done      <= 1'b0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_addr_s    <= '0;
      r_addr_c    <= '0;
      r_neg_s1    <= 1'b0;
      r_neg_c1    <= 1'b0;
      r_neg_s2    <= 1'b0;
      r_neg_c2    <= 1'b0;
      r_data      <= '0;
      r_data_vld  <= 1'b0;
    end else begin
      r_freq <= w_freq_nxt;
      r_done <= w_done_nxt;
      if ((r_state == ST_IDLE) || !MODULE_ENA) begin
        r_phase     <= '0;
        r_dwell_cnt <= '0;
        r_v1        <= 1'b0;
        r_v2        <= 1'b0;
        r_addr_s    <= '0;
        r_addr_c    <= '0;
        r_neg_s1    <= 1'b0;
        r_neg_c1    <= 1'b0;
        r_neg_s2    <= 1'b0;
        r_neg_c2    <= 1'b0;
        r_data      <= '0;
        r_data_vld  <= 1'b0;
      end else begin
        r_phase     <= r_phase + r_freq;
        r_dwell_cnt <= w_tick ? '0 : r_dwell_cnt + DWELL_W'(1);
        r_v1        <= 1'b1;
        r_addr_s    <= w_q[0] ? ~w_a : w_a;
        r_addr_c    <= w_qc[0] ? ~w_a : w_a;
        r_neg_s1    <= w_q[1];
        r_neg_c1    <= w_qc[1];
        r_v2        <= r_v1;
        r_neg_s2    <= r_neg_s1;
        r_neg_c2    <= r_neg_c1;
        r_data_vld  <= r_v2;
        r_data      <= r_v2 ? {w_sin, w_cos} : '0;
      end
    end
  end

  assign DDS_DATA       = r_data;
  assign DDS_DATA_VALID = r_data_vld;
  assign CUR_FREQ       = r_freq;
  assign sweep_done     = r_done;
  assign busy           = (r_state != ST_IDLE);
  assign cfg_ready      = (r_state == ST_IDLE);

endmodule

// File: doc/dds_sweep_gen.md
# dds_sweep_gen

Parametrised phase-accumulator DDS with an in-house quarter-wave sine/cosine ROM. Supports single-tone, sawtooth-sweep and triangle-sweep modes. It replaces the fixed single-tone vendor DDS core in the TX signal path and feeds the modulator with a packed sine/cosine word plus a valid strobe. Configuration goes in through a ready/valid port while the block is idle.

## Interface
- PHASE_W, 32, phase accumulator and frequency-word width
- OUT_W, 16, signed sample width per component
- LUT_AW, 10, quarter-wave ROM address bits (2^LUT_AW entries)
- DWELL_W, 16, dwell counter width
- GCLK  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- MODULE_ENA  in  1  run enable; high = generate, low = return to IDLE
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration accepted when valid&&ready; high only in IDLE
- cfg_mode  in  2  0 = TONE, 1 = SAW, 2 = TRI, 3 = treated as TONE
- cfg_fstart / cfg_fstop / cfg_fstep  in  PHASE_W each  unsigned frequency words
- cfg_dwell  in  DWELL_W  extra cycles per frequency step (0 = step every cycle)
- DDS_DATA_VALID  out  1  DDS_DATA holds a sample
- DDS_DATA  out  2*OUT_W  {sin, cos}; sin in the upper half, two's complement
- CUR_FREQ  out  PHASE_W  frequency word currently applied to the accumulator
- sweep_done  out  1  one-cycle pulse when a sweep period completes
- busy  out  1  state != IDLE

## Operation
- Config registers hold mode, fstart, fstop, fstep and dwell. They reset to 0/TONE and load on the cfg handshake.
- Sweep validity:
  - A sweep mode is valid only if fstep != 0 and fstep <= fstop - fstart (with fstop > fstart).
  - An invalid sweep config runs as TONE at fstart.
- States:
  - IDLE: phase = 0, f = fstart, dwell counter = 0, pipeline valid bits cleared.
  - IDLE -> RUN_UP: MODULE_ENA high.
  - RUN_UP / RUN_DOWN: any state -> IDLE on MODULE_ENA low, same cycle it is sampled.
- Accumulator: in RUN, phase <= phase + f each cycle, modulo 2^PHASE_W.
- Dwell counter: counts 0..cfg_dwell. When it reaches cfg_dwell it clears and a frequency update occurs. TONE mode never updates f.
- Frequency update, SAW:
  - If next = f + fstep ≤ fstop with no carry, then f = next.
  - Otherwise f = fstart and sweep_done pulses.
- Frequency update, TRI up:
  - Same test as SAW.
  - On overflow, go to RUN_DOWN and f = f - fstep.
- Frequency update, TRI down:
  - If next = f - fstep ≥ fstart with no borrow, then f = next; sweep_done pulses when next == fstart.
  - Otherwise go to RUN_UP and f = f + fstep.
- Sample generation:
  - q = phase[PHASE_W-1 -: 2]; a = next LUT_AW bits.
  - sin: q=0 → +rom[a]; q=1 → +rom[~a]; q=2 → -rom[a]; q=3 → -rom[~a].
  - cos uses q+1 with the same mapping.
- ROM contents: rom[i] = round((2^(OUT_W-1)-1)·sin(2π(i+0.5)/2^(LUT_AW+2))).
- The output is never tristated.

## Timing
- Reset values: DDS_DATA 0, DDS_DATA_VALID 0, CUR_FREQ 0, sweep_done 0, busy 0, cfg_ready 1. State = IDLE, all internal registers 0.
- Enable: MODULE_ENA sampled high at edge t gives busy=1 and phase=0 after edge t. The first valid sample (phase 0) appears after edge t+3; one sample follows per cycle after that.
- Pipeline: phase reg → quadrant/address reg → ROM output reg → sign-applied output reg. Latency from phase register to DDS_DATA is 3 cycles.
- A frequency update at edge u takes effect in the accumulator at edge u+1. CUR_FREQ changes at edge u. sweep_done is registered and high for the cycle after edge u.
- Disable: MODULE_ENA sampled low at edge t gives DDS_DATA_VALID=0, DDS_DATA=0 and cfg_ready=1 after edge t. In-flight samples are discarded, and re-enable restarts at fstart with phase 0.
- cfg_valid while busy is ignored (cfg_ready=0). Enable and cfg handshake in the same IDLE cycle: the new config is loaded and used by the started run.
- Asynchronous reset mid-run forces the reset values immediately. Operation resumes only after reset is released and MODULE_ENA is sampled high.

## Structure
- Package dds_pkg: mode encoding (TONE/SAW/TRI), state enum (IDLE/RUN_UP/RUN_DOWN), default parameter constants.
- Sub-module dds_sine_rom: dual-read quarter-wave ROM with registered outputs, parametrised by LUT_AW and OUT_W, contents generated at elaboration.

## Test plan
All scenarios use default parameters (rom[0]=25, rom[1023]=32767).
- Reset: assert reset mid-run → all outputs at reset values at once; cfg_ready=1.
- TONE fstart=2^30: sin sequence 25, 32767, -25, -32767 repeating. First valid exactly 3 cycles after busy rises.
- SAW fstart=100, fstop=400, fstep=100, dwell=3: CUR_FREQ 100, 200, 300, 400, each held 4 cycles, then back to 100. sweep_done pulses once per 16 cycles.
- TRI with the same values: CUR_FREQ 100, 200, 300, 400, 300, 200, 100, 200, … sweep_done pulses on the 200→100 update only.
- Invalid sweep (SAW, fstep=500 > 300): behaves as TONE at 100, sweep_done never pulses.
- Handshake and disable:
  - cfg_valid while busy is not accepted.
  - Drop MODULE_ENA mid-sweep → valid low next cycle.
  - Re-enable → CUR_FREQ = fstart, first sample again after 3 cycles.
